// File: rtl/baud_pkg.sv
// Constants for the fractional-N baud tick generator.
// They are derived from the clock, baud and oversampling parameters at elaboration time.
package baud_pkg;

   function automatic int unsigned calc_ftick(input int unsigned baud, input int unsigned osr);
      return baud * osr;
   endfunction

   function automatic int unsigned calc_n0(input int unsigned f_clk, input int unsigned baud,
                                           input int unsigned osr);
      return f_clk / calc_ftick(baud, osr);
   endfunction

   // Remainder numerator: over FTICK intervals, exactly R of them are one clock longer.
   function automatic int unsigned calc_r(input int unsigned f_clk, input int unsigned baud,
                                          input int unsigned osr);
      return f_clk - calc_n0(f_clk, baud, osr) * calc_ftick(baud, osr);
   endfunction

   function automatic int unsigned calc_acc_w(input int unsigned baud, input int unsigned osr);
      return $clog2(2 * calc_ftick(baud, osr));
   endfunction

   function automatic int unsigned calc_cnt_w(input int unsigned n0);
      return $clog2(n0 + 2);
   endfunction

   function automatic bit params_ok(input int unsigned n0, input int unsigned osr);
      return (n0 >= 2) && (osr >= 1);
   endfunction

endpackage

// File: rtl/baud_gen_top_frac_tick_gen.sv
// Dual-modulus period counter (N0 or N0+1 clocks) steered by a phase accumulator.
// The counter emits a registered single-cycle tick, plus a combinational "issuing this edge" flag.
module frac_tick_gen #(
   parameter int unsigned N0    = 27,
   parameter int unsigned R     = 233_600,
   parameter int unsigned FTICK = 1_843_200,
   parameter int unsigned ACC_W = 22,
   parameter int unsigned CNT_W = 5
) (
   input  logic clk,
   input  logic rst_n,
   output logic issue_o,
   output logic tick_o
);

   localparam logic [ACC_W-1:0] R_A     = ACC_W'(R);
   localparam logic [ACC_W-1:0] FTICK_A = ACC_W'(FTICK);
   localparam logic [CNT_W-1:0] LAST_S  = CNT_W'(N0 - 1);
   localparam logic [CNT_W-1:0] LAST_L  = CNT_W'(N0);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] sum;
   logic             long_q, long_d;
   logic             tick_q;

   // acc < FTICK always holds, so acc + R < 2*FTICK fits ACC_W bits.
   assign sum     = acc_q + R_A;
   assign issue_o = (cnt_q == (long_q ? LAST_L : LAST_S));
   assign tick_o  = tick_q;

   always_comb begin
      cnt_d  = cnt_q + 1'b1;
      acc_d  = acc_q;
      long_d = long_q;
      if (issue_o) begin
         cnt_d = '0;
         if (sum >= FTICK_A) begin
            acc_d  = sum - FTICK_A;
            long_d = 1'b1;
         end else begin
            acc_d  = sum;
            long_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         acc_q  <= '0;
         long_q <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         acc_q  <= acc_d;
         long_q <= long_d;
         tick_q <= issue_o;
      end
   end

endmodule

// File: rtl/baud_gen_top.sv
// This block generates the UART oversample strobe and the bit strobe from a fractional-N divider.
// tick_bit is raised together with every OSR-th tick_osr.
module baud_gen_top
   import baud_pkg::*;
#(
   parameter int unsigned F_CLK = 50_000_000,
   parameter int unsigned BAUD  = 115_200,
   parameter int unsigned OSR   = 16
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick_osr,
   output logic tick_bit
);

   localparam int unsigned FTICK = calc_ftick(BAUD, OSR);
   localparam int unsigned N0    = calc_n0(F_CLK, BAUD, OSR);
   localparam int unsigned R     = calc_r(F_CLK, BAUD, OSR);
   localparam int unsigned ACC_W = calc_acc_w(BAUD, OSR);
   localparam int unsigned CNT_W = calc_cnt_w(N0);
   localparam int unsigned OC_W  = (OSR > 1) ? $clog2(OSR) : 1;

   if (!params_ok(N0, OSR)) begin : g_param_check
      $fatal(1, "baud_gen_top: need N0 >= 2 and OSR >= 1");
   end

   logic            issue;
   logic            last_osr;
   logic [OC_W-1:0] oc_q, oc_d;
   logic            tick_bit_q, tick_bit_d;

   frac_tick_gen #(
      .N0    (N0),
      .R     (R),
      .FTICK (FTICK),
      .ACC_W (ACC_W),
      .CNT_W (CNT_W)
   ) u_frac (
      .clk     (clk),
      .rst_n   (rst_n),
      .issue_o (issue),
      .tick_o  (tick_osr)
   );

   assign last_osr = (oc_q == OC_W'(OSR - 1));
   assign tick_bit = tick_bit_q;

   // Registering on the same issue edge keeps tick_bit aligned with tick_osr.
   always_comb begin
      oc_d       = oc_q;
      tick_bit_d = 1'b0;
      if (issue) begin
         tick_bit_d = last_osr;
         oc_d       = last_osr ? '0 : oc_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         oc_q       <= '0;
         tick_bit_q <= 1'b0;
      end else begin
         oc_q       <= oc_d;
         tick_bit_q <= tick_bit_d;
      end
   end

endmodule

// File: tb/tb_baud_gen_top.sv
// Bench for baud_gen_top: default instance (fractional divider) plus an R=0 instance.
// Expected spacing comes from the floor(n*R/FTICK) rule.
module tb_baud_gen_top;

   localparam longint unsigned FT   = 64'd1_843_200;
   localparam longint unsigned RR   = 64'd233_600;
   localparam int              N0   = 27;
   localparam int              OSRV = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic a_osr, a_bit, b_osr, b_bit;

   always #5 clk = ~clk;

   baud_gen_top u_dut_a (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick_osr (a_osr),
      .tick_bit (a_bit)
   );

   baud_gen_top #(.F_CLK(49_766_400), .BAUD(115_200), .OSR(16)) u_dut_b (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick_osr (b_osr),
      .tick_bit (b_bit)
   );

   int   n_assert = 0;
   int   n_fail   = 0;
   int   a_since, a_ticks, n_long;
   int   b_since, b_ticks, b_bit_since;
   bit   b_bit_valid;
   logic pa_osr = 1'b0;
   logic pb_osr = 1'b0;

   function automatic bit is_long(input int n);
      longint unsigned hi, lo;
      hi = (longint'(n) * RR) / FT;
      lo = (longint'(n - 1) * RR) / FT;
      return hi != lo;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_trackers();
      a_since     = 0;
      a_ticks     = 0;
      n_long      = 0;
      b_since     = 0;
      b_ticks     = 0;
      b_bit_since = 0;
      b_bit_valid = 1'b0;
   endtask

   // One clock: sample away from the edge, run per-cycle checks, track the R=0 instance.
   task automatic step();
      @(negedge clk);
      a_since++;
      b_since++;
      b_bit_since++;
      if (rst_n) begin
         chk("a_bit_without_osr", 32'(a_bit & ~a_osr), 0);
         chk("a_osr_back_to_back", 32'(a_osr & pa_osr), 0);
         chk("b_bit_without_osr", 32'(b_bit & ~b_osr), 0);
         chk("b_osr_back_to_back", 32'(b_osr & pb_osr), 0);
         if (b_osr) begin
            chk("b_gap", 32'(b_since), 32'(N0));
            b_since = 0;
            b_ticks++;
            chk("b_bit_phase", 32'(b_bit), 32'((b_ticks % OSRV) == 0));
            if (b_bit) begin
               if (b_bit_valid) chk("b_bit_gap", 32'(b_bit_since), 32'(N0 * OSRV));
               b_bit_since = 0;
               b_bit_valid = 1'b1;
            end
         end
      end
      pa_osr = a_osr;
      pb_osr = b_osr;
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst_n = 1'b0;
      for (int i = 0; i < n; i++) begin
         step();
         chk("rst_outputs", 32'({a_osr, a_bit, b_osr, b_bit}), 0);
      end
      rst_n = 1'b1;
      clear_trackers();
   endtask

   task automatic run_ticks(input int n);
      for (int k = 0; k < n; k++) begin
         bit got;
         int exp_gap;
         got = 1'b0;
         for (int c = 0; c < 40; c++) begin
            step();
            if (a_osr) begin
               got = 1'b1;
               break;
            end
         end
         chk("a_tick_timeout", 32'(got), 1);
         if (!got) return;
         a_ticks++;
         exp_gap = (a_ticks == 1) ? N0 : (is_long(a_ticks - 1) ? N0 + 1 : N0);
         chk("a_gap", 32'(a_since), 32'(exp_gap));
         if (a_since == N0 + 1) n_long++;
         a_since = 0;
         chk("a_bit_phase", 32'(a_bit), 32'((a_ticks % OSRV) == 0));
      end
   endtask

   initial begin
      int off;
      int extra;
      longint unsigned exp_long;
      clear_trackers();

      do_reset(5);
      run_ticks(2000);
      exp_long = (64'd1999 * RR) / FT;
      chk("long_count_window", 32'(n_long >= 233 && n_long <= 273), 1);
      chk("long_count_exact", 32'(n_long), 32'(exp_long));

      extra = 7 + OSRV * int'($urandom_range(0, 3));
      run_ticks(extra);
      off = int'($urandom_range(0, 20));
      repeat (off) step();
      do_reset(3);
      run_ticks(300);
      exp_long = (64'd299 * RR) / FT;
      chk("long_count_after_reset", 32'(n_long), 32'(exp_long));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
